seq10010_tx: RTL and testbench
==============================

# seq10010_tx

Serial frame transmitter that feeds the "10010" sequence detector. It accepts a DATA_W-bit word over a valid/ready handshake and shifts out one frame on `seq`, one bit per clock: the 5-bit sync header 1-0-0-1-0, then the payload MSB first, then GAP zero guard bits. It sits in the same clock domain as the detector and drives the detector's `seq` input directly.

## Interface
- `DATA_W`, default 8: payload width in bits, must be ≥1.
- `GAP`, default 2: number of zero guard bits after the payload, must be ≥0.
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: asynchronous, active-high reset.
- `data_in`  input  DATA_W: payload word, sampled only on accept.
- `load`  input  1: source valid; a frame is accepted on a rising edge where `load && ready`.
- `ready`  output  1: high only in state IDLE; decoded from state, not from `load`.
- `seq`  output  1: registered serial bit stream.
- `busy`  output  1: high in HDR, DATA and GAP.
- `frame_done`  output  1: registered one-cycle pulse at frame completion.

## Operation
- States:
  - IDLE: `seq`=0, `ready`=1.
  - HDR: 5 bits, taken from a constant header register 10010, MSB first.
  - DATA: DATA_W bits, shifted out of a payload register.
  - GAP: GAP bits, `seq`=0.
- Transitions:
  - IDLE→HDR on accept. On the same edge `data_in` is copied into the shift register and `seq` is loaded with header bit 4 (1).
  - HDR→DATA after the 5th header bit.
  - DATA→GAP after the last payload bit. If GAP=0, DATA→IDLE directly.
  - GAP→IDLE after the last guard bit.
- Bit counter width is clog2(max(5, DATA_W, GAP, 1))+1. It is reloaded on each state entry and counts down to 0. It never wraps within a state.
- Frame length is L = 5 + DATA_W + GAP.
- `load` is ignored while busy. `data_in` changes after accept do not affect the frame in flight.
- Payload is sent verbatim. The block performs no bit-stuffing. A payload containing 10010 will trigger the detector, and preventing that is the source's responsibility.
- Unused/illegal state encodings return to IDLE on the next clock with `seq`=0.
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE, shift register=0, counter=0.
  - `seq`=0, `frame_done`=0, `busy`=0, `ready`=1.
  - An aborted frame produces no `frame_done` and is not resumed.

## Timing
- Accept at edge k: frame bit i (i=0..L-1) is driven on `seq` from edge k+i to edge k+i+1.
  - Bits 0..4 = 1,0,0,1,0.
  - Bits 5..4+DATA_W = `data_in`[DATA_W-1..0].
  - Remaining bits = 0.
- Edge k+L:
  - state=IDLE, `seq`=0.
  - `frame_done`=1 for exactly one cycle (edge k+L to k+L+1).
  - `ready`=1.
- The earliest next accept is at edge k+L+1, so back-to-back frames are separated by at least one IDLE zero bit. Accept period ≥ L+1 cycles.
- `busy` is high from edge k to edge k+L.
- The detector downstream registers its match on the edge after header bit 4. Its `b` is therefore high from edge k+5 to k+6.
- There is no combinational path from `load` or `data_in` to `seq`.

## Test plan
- Reset: assert `rst` asynchronously between edges → `seq`=0, `busy`=0, `frame_done`=0 and `ready`=1 immediately. They hold while `rst`=1 regardless of `load`.
- Single frame, DATA_W=8, GAP=2, `data_in`=8'hF0, `load` pulsed one cycle → `seq` = 1,0,0,1,0,1,1,1,1,0,0,0,0,0,0 over edges k..k+14. `frame_done` pulses at k+15. The attached detector pulses `b` exactly once, at k+5.
- Payload containing the pattern, `data_in`=8'hA5 → bits 10010_10100101_00 emitted verbatim. The detector pulses `b` at k+5 and again after payload bit 6 (k+12).
- Busy-ignore and back-to-back:
  - Hold `load`=1 continuously with `data_in` toggling every cycle → one frame per 16 cycles.
  - Each frame carries the word present at its accept edge.
  - Exactly one 0 bit separates frames.
  - `load` during busy never alters the stream.
- Reset mid-frame: `rst` pulsed during DATA bit 3 → `seq`=0 at once, no `frame_done`. A new `load` after release sends a complete fresh frame starting with header 1.
- Parameter corner, DATA_W=1, GAP=0, `data_in`=1 → `seq` = 1,0,0,1,0,1 then IDLE. `frame_done` at k+6, next accept possible at k+7.

Source files
------------

// File: rtl/seq10010_tx.sv
// Serial frame transmitter: 10010 sync header, payload MSB first, then GAP zero guard bits.
// One bit per clock on a registered `seq`; accepts a new word only from IDLE.
module seq10010_tx #(
   parameter int DATA_W = 8,
   parameter int GAP    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load,
   output logic              ready,
   output logic              seq,
   output logic              busy,
   output logic              frame_done
);

   localparam int MAXB = (DATA_W > GAP) ? ((DATA_W > 5) ? DATA_W : 5)
                                        : ((GAP > 5) ? GAP : 5);
   localparam int CW = $clog2(MAXB) + 1;
   localparam logic [CW-1:0] HDR_LD = CW'(4);
   localparam logic [CW-1:0] DAT_LD = CW'(DATA_W - 1);
   localparam logic [CW-1:0] GAP_LD = (GAP > 0) ? CW'(GAP - 1) : '0;
   // Header 10010 with bit 4 already consumed on the accept edge.
   localparam logic [4:0]    HDR_REST = 5'b00100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_DATA = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [4:0]        hdr_q, hdr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              seq_q, seq_d;
   logic              done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         hdr_q   <= '0;
         cnt_q   <= '0;
         seq_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         hdr_q   <= hdr_d;
         cnt_q   <= cnt_d;
         seq_q   <= seq_d;
         done_q  <= done_d;
      end
   end

   // cnt_q holds the number of bits still to follow in the current state.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      hdr_d   = hdr_q;
      cnt_d   = cnt_q;
      seq_d   = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load) begin
               state_d = S_HDR;
               shift_d = data_in;
               hdr_d   = HDR_REST;
               cnt_d   = HDR_LD;
               seq_d   = 1'b1;
            end
         end
         S_HDR: begin
            if (cnt_q == '0) begin
               state_d = S_DATA;
               seq_d   = shift_q[DATA_W-1];
               shift_d = shift_q << 1;
               cnt_d   = DAT_LD;
            end else begin
               seq_d = hdr_q[4];
               hdr_d = hdr_q << 1;
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               if (GAP > 0) begin
                  state_d = S_GAP;
                  cnt_d   = GAP_LD;
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end
            end else begin
               seq_d   = shift_q[DATA_W-1];
               shift_d = shift_q << 1;
               cnt_d   = cnt_q - 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign ready      = (state_q == S_IDLE);
   assign busy       = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_GAP);
   assign seq        = seq_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_seq10010_tx.sv
// Bench for seq10010_tx: stimulus pushes expected frame bits; per-instance monitors pop and compare.
module tb_seq10010_tx;

   localparam int DW0 = 8, G0 = 2;
   localparam int DW1 = 1, G1 = 0;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [DW0-1:0] data_in0 = '0;
   logic [DW1-1:0] data_in1 = '0;
   logic load0 = 1'b0, load1 = 1'b0;
   logic ready0, seq0, busy0, frame_done0;
   logic ready1, seq1, busy1, frame_done1;

   int checks = 0;
   int errors = 0;

   bit exp0[$];
   bit exp1[$];
   int frames_exp0 = 0, frames_exp1 = 0;
   int done_cnt0 = 0, done_cnt1 = 0;
   bit prev_busy0 = 1'b0, prev_busy1 = 1'b0;

   seq10010_tx #(.DATA_W(DW0), .GAP(G0)) u0 (
      .clk(clk), .rst(rst), .data_in(data_in0), .load(load0),
      .ready(ready0), .seq(seq0), .busy(busy0), .frame_done(frame_done0));

   seq10010_tx #(.DATA_W(DW1), .GAP(G1)) u1 (
      .clk(clk), .rst(rst), .data_in(data_in1), .load(load1),
      .ready(ready1), .seq(seq1), .busy(busy1), .frame_done(frame_done1));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push0(input logic [DW0-1:0] w);
      logic [4:0] h;
      h = 5'b10010;
      for (int i = 4; i >= 0; i--) exp0.push_back(h[i]);
      for (int i = DW0-1; i >= 0; i--) exp0.push_back(w[i]);
      for (int i = 0; i < G0; i++) exp0.push_back(1'b0);
      frames_exp0++;
   endtask

   task automatic push1(input logic [DW1-1:0] w);
      logic [4:0] h;
      h = 5'b10010;
      for (int i = 4; i >= 0; i--) exp1.push_back(h[i]);
      for (int i = DW1-1; i >= 0; i--) exp1.push_back(w[i]);
      for (int i = 0; i < G1; i++) exp1.push_back(1'b0);
      frames_exp1++;
   endtask

   // Monitor for the 8-bit instance.
   always @(negedge clk) begin
      if (rst) begin
         prev_busy0 = 1'b0;
      end else begin
         if (busy0) begin
            if (exp0.size() == 0) check("u0_unexpected_busy", 1, 0);
            else check("u0_seq", seq0, exp0.pop_front());
         end else begin
            check("u0_idle_seq", seq0, 0);
            if (prev_busy0) check("u0_frame_done", frame_done0, 1);
         end
         check("u0_ready", ready0, !busy0);
         if (frame_done0) begin
            done_cnt0++;
            check("u0_done_at_end", {prev_busy0, busy0, exp0.size() == 0}, 3'b101);
         end
         prev_busy0 = busy0;
      end
   end

   // Monitor for the DATA_W=1, GAP=0 instance.
   always @(negedge clk) begin
      if (rst) begin
         prev_busy1 = 1'b0;
      end else begin
         if (busy1) begin
            if (exp1.size() == 0) check("u1_unexpected_busy", 1, 0);
            else check("u1_seq", seq1, exp1.pop_front());
         end else begin
            check("u1_idle_seq", seq1, 0);
            if (prev_busy1) check("u1_frame_done", frame_done1, 1);
         end
         check("u1_ready", ready1, !busy1);
         if (frame_done1) begin
            done_cnt1++;
            check("u1_done_at_end", {prev_busy1, busy1, exp1.size() == 0}, 3'b101);
         end
         prev_busy1 = busy1;
      end
   end

   task automatic send0(input logic [DW0-1:0] w);
      int t;
      t = 0;
      while (!ready0 && t < 100) begin
         @(posedge clk); #1; t++;
      end
      check("u0_ready_timeout", ready0, 1);
      load0 = 1'b1;
      data_in0 = w;
      @(posedge clk);
      push0(w);
      #1;
      load0 = 1'b0;
      data_in0 = ~w;
   endtask

   task automatic drain0();
      int t;
      t = 0;
      while ((busy0 || exp0.size() != 0) && t < 200) begin
         @(posedge clk); #1; t++;
      end
      check("u0_drain_timeout", t < 200, 1);
      @(posedge clk); #1;
   endtask

   task automatic drain1();
      int t;
      t = 0;
      while ((busy1 || exp1.size() != 0) && t < 200) begin
         @(posedge clk); #1; t++;
      end
      check("u1_drain_timeout", t < 200, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      // Asynchronous reset before the first clock edge, with load held high.
      load0 = 1'b1; load1 = 1'b1; data_in0 = 8'hFF; data_in1 = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("rst_seq", seq0, 0);
      check("rst_busy", busy0, 0);
      check("rst_done", frame_done0, 0);
      check("rst_ready", ready0, 1);
      check("rst_u1", {seq1, busy1, frame_done1, ready1}, 4'b0001);
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold_busy", {busy0, busy1, seq0, seq1}, 4'b0000);
      load0 = 1'b0; load1 = 1'b0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Plain payload, then a payload that itself contains 10010.
      send0(8'hF0);
      drain0();
      send0(8'hA5);
      drain0();

      // load held high with data toggling: accepts every 16 cycles.
      load0 = 1'b1;
      for (int c = 0; c < 48; c++) begin
         data_in0 = 8'h30 + 8'(c * 7);
         @(posedge clk);
         if (c % 16 == 0) push0(data_in0);
         #1;
      end
      load0 = 1'b0;
      drain0();

      // Abort during payload bit 3; the aborted frame must not complete.
      send0(8'hC3);
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b1;
      exp0.delete();
      frames_exp0--;
      #1;
      check("abort_seq", seq0, 0);
      check("abort_busy", busy0, 0);
      check("abort_done", frame_done0, 0);
      check("abort_ready", ready0, 1);
      load0 = 1'b1;
      @(posedge clk); #1;
      check("abort_hold", {busy0, seq0}, 2'b00);
      load0 = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      send0(8'h5A);
      drain0();

      // Narrow instance: accepts every 7 cycles with continuous load.
      load1 = 1'b1;
      for (int c = 0; c < 14; c++) begin
         data_in1 = ~c[0];
         @(posedge clk);
         if (c % 7 == 0) push1(data_in1);
         #1;
      end
      load1 = 1'b0;
      drain1();

      check("u0_queue_empty", exp0.size(), 0);
      check("u1_queue_empty", exp1.size(), 0);
      check("u0_frame_count", done_cnt0, frames_exp0);
      check("u1_frame_count", done_cnt1, frames_exp1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
